reloadable_counter: RTL and testbench
=====================================

Name: reloadable_counter

Overview:
- Parametrised reloadable up/down counter; next generation of the lab's 8-bit reloadable up counter.
- Adds:
  - configurable width and modulus
  - count direction control
  - count enable
  - synchronised, edge-detected reload from an asynchronous push-button
  - terminal-count and wrap flags
- Sits between board push-buttons/switches and display or timing logic.
- Single clock domain, synchronous active-high reset.

Parameters:
- WIDTH, 8, counter width in bits (>=2).
- MAX_VAL, 2**WIDTH-1, upper count limit; count range is 0..MAX_VAL (must be <= 2**WIDTH-1).
- RESET_VAL, 0, value loaded into COUNT on reset (must be <= MAX_VAL).
- SYNC_STAGES, 2, synchroniser flops on LOAD_BTN (>=2).

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RESET_BTN  input  1  synchronous, active-high reset.
- EN  input  1  count enable, synchronous to CLK.
- UP_DN  input  1  direction: 1 = up, 0 = down; synchronous to CLK.
- LOAD_BTN  input  1  asynchronous reload request (push-button); synchronised internally.
- LOAD_VAL  input  WIDTH  reload value; must be stable while a reload is in flight.
- COUNT  output  WIDTH  registered counter value.
- TC  output  1  combinational terminal count: COUNT==MAX_VAL when UP_DN=1, COUNT==0 when UP_DN=0.
- WRAP  output  1  registered one-cycle pulse following a wrap-around edge.

Behaviour:
- Clock and reset: one clock, CLK. Reset RESET_BTN is synchronous and active-high.
- Reset (RESET_BTN=1 at a CLK edge):
  - COUNT<=RESET_VAL, WRAP<=0.
  - All synchroniser and edge-detect flops <=0.
  - TC then follows from COUNT/UP_DN.
- Priority per edge: reset > reload > count > hold.
- Reload path:
  - LOAD_BTN feeds a SYNC_STAGES-deep flop chain, followed by one edge-detect flop (prev).
  - load_pulse = last_stage & ~prev.
  - One reload per button press, regardless of how long it is held.
  - Latency: if LOAD_BTN is first sampled high at edge k, COUNT=LOAD_VAL after edge k+SYNC_STAGES.
  - LOAD_VAL is sampled at that edge.
  - If LOAD_VAL>MAX_VAL, COUNT<=MAX_VAL (clamped).
  - A reload edge sets WRAP<=0 and suppresses counting on that edge.
- Count path (no reset, no load_pulse, EN=1):
  - UP_DN=1: COUNT<MAX_VAL gives COUNT+1. COUNT==MAX_VAL gives wrap to 0, WRAP<=1.
  - UP_DN=0: COUNT>0 gives COUNT-1. COUNT==0 gives wrap to MAX_VAL, WRAP<=1.
  - Any non-wrapping edge: WRAP<=0.
- EN=0: COUNT holds, WRAP<=0.
- Out-of-range state (COUNT>MAX_VAL, unreachable in normal use): next count edge forces COUNT<=0.
- Arithmetic: unsigned, WIDTH bits. No intermediate result is ever allowed to overflow WIDTH, even when MAX_VAL=2**WIDTH-1.
- Direction change: takes effect on the same edge UP_DN is sampled. TC re-evaluates immediately, because it is combinational.
- Reset mid-reload (RESET_BTN asserted while a press is in the synchroniser): pending reload is discarded. A still-held button generates no reload after reset release; it must be released and pressed again.

Optional Feature:
- Macro: SATURATE_EN.
- Defined:
  - Counter saturates: up at MAX_VAL holds MAX_VAL; down at 0 holds 0.
  - WRAP is tied to 0.
  - TC behaviour unchanged.
- Undefined: wrap-around behaviour as in Behaviour. WRAP is active.

Test Plan:
- Reset/hold: RESET_BTN=1 for 2 cycles, then EN=0 for 5 cycles -> COUNT=0x00, WRAP=0, TC=0 (UP_DN=1) for all cycles.
- Up wrap, WIDTH=8, MAX_VAL=9: EN=1, UP_DN=1 for 12 cycles -> COUNT 1..9, 0, 1, 2. WRAP=1 only in the cycle after COUNT 9->0. TC=1 while COUNT=9.
- Down wrap: load 2, EN=1, UP_DN=0 for 4 cycles -> COUNT 1, 0, 9, 8. WRAP pulses once after 0->9. With SATURATE_EN: COUNT 1, 0, 0, 0 and WRAP=0.
- Reload latency/one-shot, SYNC_STAGES=2: LOAD_VAL=0x05, LOAD_BTN held high 10 cycles from edge k, EN=0 -> COUNT=5 after edge k+2, no further reloads. LOAD_VAL=0xC8 (>MAX_VAL=9) on a second press -> COUNT=9.
- Load vs count collision: EN=1, UP_DN=1, COUNT=9 on the edge load_pulse fires with LOAD_VAL=3 -> COUNT=3, WRAP=0.
- Reset mid-reload: press LOAD_BTN, assert RESET_BTN one cycle later for 1 cycle, keep button held -> COUNT=RESET_VAL, no reload until release and re-press.

Source files
------------

// File: rtl/reloadable_counter_if.sv
// Purpose : control/status bundle between push-button/switch logic and the reloadable counter.
// Latency : n/a (wires only).
// Backpressure: none; the counter accepts control inputs on every clock edge.
// Ports   : EN, UP_DN, LOAD_BTN, LOAD_VAL -> counter; COUNT, TC, WRAP <- counter.
//           master = board/control side, slave = counter side.
interface reloadable_counter_if #(
  parameter int unsigned WIDTH = 8
);
  logic             EN;
  logic             UP_DN;
  logic             LOAD_BTN;
  logic [WIDTH-1:0] LOAD_VAL;
  logic [WIDTH-1:0] COUNT;
  logic             TC;
  logic             WRAP;

  modport master (
    output EN, UP_DN, LOAD_BTN, LOAD_VAL,
    input  COUNT, TC, WRAP
  );

  modport slave (
    input  EN, UP_DN, LOAD_BTN, LOAD_VAL,
    output COUNT, TC, WRAP
  );
endinterface

// File: rtl/reloadable_counter.sv
// Purpose : parametrised up/down counter with enable, synchronised one-shot push-button
//           reload (clamped to MAX_VAL), combinational terminal count and a registered wrap pulse.
// Latency : COUNT updates one edge after EN/UP_DN; reload lands SYNC_STAGES edges after the
//           button is first sampled high. Backpressure: none, every edge is accepted.
// Ports   : CLK, RESET_BTN (sync, active-high); bus (slave modport): EN, UP_DN, LOAD_BTN,
//           LOAD_VAL in; COUNT, TC, WRAP out.
// Build option: define SATURATE_EN to make the counter saturate at 0/MAX_VAL (WRAP stays 0).
module reloadable_counter #(
  parameter int unsigned      WIDTH       = 8,
  parameter logic [WIDTH-1:0] MAX_VAL     = {WIDTH{1'b1}},
  parameter logic [WIDTH-1:0] RESET_VAL   = '0,
  parameter int unsigned      SYNC_STAGES = 2
) (
  input  logic               CLK,
  input  logic               RESET_BTN,
  reloadable_counter_if.slave bus
);

  // fill_q counts edges since reset until both the last sync stage and prev hold real
  // button samples. Until then the edge detector is blind, so a button still held
  // through reset cannot masquerade as a fresh press once the zeroed chain refills.
  localparam int unsigned      FILL_W    = $clog2(SYNC_STAGES + 2);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic [FILL_W-1:0]      fill_q, fill_d;
  logic [WIDTH-1:0]       count_q, count_d;
  logic                   wrap_q, wrap_d;

  logic                   load_pulse;
  logic                   out_of_range;
  logic [WIDTH-1:0]       load_val_clamped;

  // With MAX_VAL at all-ones, nothing can exceed it; drop the comparisons entirely.
  generate
    if (MAX_VAL == {WIDTH{1'b1}}) begin : g_full_range
      assign out_of_range     = 1'b0;
      assign load_val_clamped = bus.LOAD_VAL;
    end else begin : g_sub_range
      assign out_of_range     = (count_q > MAX_VAL);
      assign load_val_clamped = (bus.LOAD_VAL > MAX_VAL) ? MAX_VAL : bus.LOAD_VAL;
    end
  endgenerate

  always_comb begin
    sync_d     = {sync_q[SYNC_STAGES-2:0], bus.LOAD_BTN};
    prev_d     = sync_q[SYNC_STAGES-1];
    fill_d     = (fill_q == FILL_FULL) ? fill_q : fill_q + FILL_W'(1);
    load_pulse = sync_q[SYNC_STAGES-1] & ~prev_q & (fill_q == FILL_FULL);

    count_d = count_q;
    wrap_d  = 1'b0;

    if (load_pulse) begin
      count_d = load_val_clamped;
    end else if (bus.EN) begin
      if (out_of_range) begin
        count_d = '0;
      end else if (bus.UP_DN) begin
        if (count_q == MAX_VAL) begin
`ifdef SATURATE_EN
          count_d = MAX_VAL;
`else
          count_d = '0;
          wrap_d  = 1'b1;
`endif
        end else begin
          // count_q < MAX_VAL <= all-ones, so the increment cannot overflow
          count_d = count_q + WIDTH'(1);
        end
      end else begin
        if (count_q == '0) begin
`ifdef SATURATE_EN
          count_d = '0;
`else
          count_d = MAX_VAL;
          wrap_d  = 1'b1;
`endif
        end else begin
          count_d = count_q - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET_BTN) begin
      sync_q  <= '0;
      prev_q  <= 1'b0;
      fill_q  <= '0;
      count_q <= RESET_VAL;
      wrap_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      fill_q  <= fill_d;
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign bus.COUNT = count_q;
  assign bus.WRAP  = wrap_q;
  assign bus.TC    = bus.UP_DN ? (count_q == MAX_VAL) : (count_q == '0);

endmodule

// File: tb/tb_reloadable_counter.sv
// Purpose : self-checking bench for reloadable_counter (WIDTH=8, MAX_VAL=9, SYNC_STAGES=2).
// Latency : n/a. Backpressure: n/a.
// Directed steps followed by random stimulus, all compared to an arithmetic reference model.
module tb_reloadable_counter;
  localparam int WIDTH = 8;
  localparam int MAXV  = 9;
  localparam int RSTV  = 0;
  localparam int S     = 2;

  logic CLK = 1'b0;
  logic RESET_BTN;
  always #5 CLK = ~CLK;

  reloadable_counter_if #(.WIDTH(WIDTH)) bus ();

  reloadable_counter #(
    .WIDTH      (WIDTH),
    .MAX_VAL    (8'(MAXV)),
    .RESET_VAL  (8'(RSTV)),
    .SYNC_STAGES(S)
  ) dut (
    .CLK      (CLK),
    .RESET_BTN(RESET_BTN),
    .bus      (bus)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: count value, wrap flag and the button samples taken since reset.
  int m_cnt  = 0;
  int m_wrap = 0;
  int hist[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance the model by one edge using the currently driven inputs, clock, then compare.
  task automatic tick(input string tag);
    int n;
    int lv;
    if (RESET_BTN) begin
      m_cnt  = RSTV;
      m_wrap = 0;
      hist.delete();
    end else begin
      n = hist.size();
      // A press is a 0->1 step between two post-reset samples, acted on S edges later.
      if (n >= S + 1 && hist[n-S] == 1 && hist[n-S-1] == 0) begin
        lv     = int'(bus.LOAD_VAL);
        m_cnt  = (lv > MAXV) ? MAXV : lv;
        m_wrap = 0;
      end else if (bus.EN) begin
        if (bus.UP_DN) begin
`ifdef SATURATE_EN
          m_wrap = 0;
          m_cnt  = (m_cnt == MAXV) ? MAXV : m_cnt + 1;
`else
          m_wrap = (m_cnt == MAXV) ? 1 : 0;
          m_cnt  = (m_cnt + 1) % (MAXV + 1);
`endif
        end else begin
`ifdef SATURATE_EN
          m_wrap = 0;
          m_cnt  = (m_cnt == 0) ? 0 : m_cnt - 1;
`else
          m_wrap = (m_cnt == 0) ? 1 : 0;
          m_cnt  = (m_cnt + MAXV) % (MAXV + 1);
`endif
        end
      end else begin
        m_wrap = 0;
      end
      hist.push_back(int'(bus.LOAD_BTN));
    end
    @(posedge CLK);
    #1;
    check({tag, ".count"}, 32'(bus.COUNT), 32'(m_cnt));
    check({tag, ".wrap"},  32'(bus.WRAP),  32'(m_wrap));
    check({tag, ".tc"},    32'(bus.TC),
          32'(bus.UP_DN ? (m_cnt == MAXV) : (m_cnt == 0)));
  endtask

  task automatic ticks(input string tag, input int n);
    for (int i = 0; i < n; i++) tick(tag);
  endtask

  initial begin
    RESET_BTN    = 1'b1;
    bus.EN       = 1'b0;
    bus.UP_DN    = 1'b1;
    bus.LOAD_BTN = 1'b0;
    bus.LOAD_VAL = '0;

    // Reset then hold.
    ticks("reset", 2);
    check("reset_count_const", 32'(bus.COUNT), 32'(RSTV));
    RESET_BTN = 1'b0;
    ticks("hold", 5);
    check("hold_tc_const", 32'(bus.TC), 32'd0);

    // Count up through the wrap.
    bus.EN = 1'b1;
    bus.UP_DN = 1'b1;
    ticks("up", 12);

    // Load 2, then count down through the wrap.
    bus.EN = 1'b0;
    bus.LOAD_VAL = 8'd2;
    bus.LOAD_BTN = 1'b1;
    ticks("load2", 3);
    check("load2_const", 32'(bus.COUNT), 32'd2);
    bus.LOAD_BTN = 1'b0;
    ticks("rel", 2);
    bus.EN = 1'b1;
    bus.UP_DN = 1'b0;
    ticks("down", 4);

    // Reload latency and one-shot behaviour with a long press.
    bus.EN = 1'b0;
    bus.UP_DN = 1'b1;
    bus.LOAD_VAL = 8'h05;
    bus.LOAD_BTN = 1'b1;
    ticks("lat", 2);
    check("lat_not_yet", 32'(bus.COUNT == 8'h05), 32'd0);
    tick("lat");
    check("lat_k2_const", 32'(bus.COUNT), 32'd5);
    ticks("held", 7);
    bus.LOAD_BTN = 1'b0;
    ticks("rel", 3);

    // Clamped reload.
    bus.LOAD_VAL = 8'hC8;
    bus.LOAD_BTN = 1'b1;
    ticks("clamp", 3);
    check("clamp_const", 32'(bus.COUNT), 32'(MAXV));
    bus.LOAD_BTN = 1'b0;
    ticks("rel", 2);

    // Reload wins over a wrapping count at COUNT=MAX.
    bus.LOAD_VAL = 8'd3;
    bus.LOAD_BTN = 1'b1;
    ticks("coll", 2);
    bus.EN = 1'b1;
    tick("coll");
    check("coll_count_const", 32'(bus.COUNT), 32'd3);
    check("coll_wrap_const", 32'(bus.WRAP), 32'd0);
    bus.EN = 1'b0;
    bus.LOAD_BTN = 1'b0;
    ticks("rel", 2);

    // Reset while a press is in flight, button kept held afterwards.
    bus.LOAD_VAL = 8'd7;
    bus.LOAD_BTN = 1'b1;
    tick("midrst_press");
    RESET_BTN = 1'b1;
    tick("midrst_rst");
    RESET_BTN = 1'b0;
    ticks("midrst_held", 6);
    check("midrst_count_const", 32'(bus.COUNT), 32'(RSTV));
    bus.LOAD_BTN = 1'b0;
    ticks("midrst_rel", 2);
    bus.LOAD_BTN = 1'b1;
    ticks("midrst_repress", 3);
    check("repress_const", 32'(bus.COUNT), 32'd7);
    bus.LOAD_BTN = 1'b0;
    ticks("rel", 2);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      RESET_BTN    = ($urandom_range(63) == 0);
      bus.EN       = ($urandom_range(3) != 0);
      bus.UP_DN    = ($urandom_range(4) != 0);
      if ($urandom_range(5) == 0) bus.LOAD_BTN = ~bus.LOAD_BTN;
      if (!bus.LOAD_BTN) bus.LOAD_VAL = 8'($urandom_range(255));
      tick("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
